// File: rtl/nat_pkg.sv
// Shared constants and types for the NAT request front end: FSM encoding,
// tuple beat indices and the request tuple payload.
package nat_pkg;

  localparam int unsigned IP_W        = 32;
  localparam int unsigned PORT_W      = 16;
  localparam int unsigned PROTO_W     = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PROTO_PAD_W = DATA_W - PROTO_W;
  localparam int unsigned LAT_W       = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SRC_IP    = 3'd1;
  localparam logic [2:0] ST_DST_IP    = 3'd2;
  localparam logic [2:0] ST_PORTS     = 3'd3;
  localparam logic [2:0] ST_PROTO     = 3'd4;
  localparam logic [2:0] ST_WAIT_CONN = 3'd5;
  localparam logic [2:0] ST_OUT       = 3'd6;

  localparam logic [1:0] BEAT_SRC_IP = 2'd0;
  localparam logic [1:0] BEAT_DST_IP = 2'd1;
  localparam logic [1:0] BEAT_PORTS  = 2'd2;
  localparam logic [1:0] BEAT_PROTO  = 2'd3;

  typedef struct packed {
    logic [IP_W-1:0]    src_ip;
    logic [IP_W-1:0]    dst_ip;
    logic [PORT_W-1:0]  src_port;
    logic [PORT_W-1:0]  dst_port;
    logic [PROTO_W-1:0] proto;
  } tuple_t;

  // Beat states are contiguous from ST_SRC_IP, so the beat index is an offset.
  function automatic logic [1:0] beat_of(input logic [2:0] st);
    return 2'(st - ST_SRC_IP);
  endfunction

endpackage

// File: rtl/nat_beat_mux.sv
// Selects the 32-bit tuple stream payload for the current beat; zero when idle.
module nat_beat_mux
  import nat_pkg::*;
(
  input  logic              beat_valid,
  input  logic [1:0]        beat_idx,
  input  tuple_t            tuple,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (beat_valid) begin
      case (beat_idx)
        BEAT_SRC_IP: data = tuple.src_ip;
        BEAT_DST_IP: data = tuple.dst_ip;
        BEAT_PORTS:  data = {tuple.dst_port, tuple.src_port};
        BEAT_PROTO:  data = {{PROTO_PAD_W{1'b0}}, tuple.proto};
      endcase
    end
  end

endmodule

// File: rtl/nat_req_frontend.sv
// NAT request front end: serialises a 5-tuple into four beats, waits for the
// connection id (with optional timeout) and returns a tagged, timed result.
module nat_req_frontend
  import nat_pkg::*;
#(
  parameter int unsigned SEQ_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [IP_W-1:0]     in_src_ip_i,
  input  logic [IP_W-1:0]     in_dst_ip_i,
  input  logic [PORT_W-1:0]   in_src_port_i,
  input  logic [PORT_W-1:0]   in_dst_port_i,
  input  logic [PROTO_W-1:0]  in_proto_i,
  output logic                in_ready_o,
  output logic                tuple_valid_o,
  output logic [DATA_W-1:0]   tuple_data_o,
  input  logic                tuple_ready_i,
  input  logic                conn_valid_i,
  input  logic [DATA_W-1:0]   conn_data_i,
  output logic                conn_ready_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DATA_W-1:0]   res_data_o,
  output logic [SEQ_W-1:0]    res_seq_o,
  output logic [LAT_W-1:0]    res_lat_o,
  output logic                res_err_o
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam bit          TO_EN   = (TIMEOUT != 0);

  logic [2:0]       state;
  logic [2:0]       next_state;
  tuple_t           tuple_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_next;
  logic [31:0]      to_cnt;
  logic [SEQ_W-1:0] seq;
  logic             beat_active;
  logic             conn_fire;
  logic             to_hit;

  assign beat_active = (state >= ST_SRC_IP) && (state <= ST_PROTO);
  assign conn_fire   = (state == ST_WAIT_CONN) && conn_valid_i;
  assign to_hit      = TO_EN && (state == ST_WAIT_CONN) && (to_cnt == TO_LAST);
  assign lat_next    = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);

  assign in_ready_o    = (state == ST_IDLE);
  assign tuple_valid_o = beat_active;
  assign conn_ready_o  = (state == ST_WAIT_CONN);
  assign res_valid_o   = (state == ST_OUT);
  assign res_seq_o     = seq;

  nat_beat_mux u_beat_mux (
    .beat_valid (beat_active),
    .beat_idx   (beat_of(state)),
    .tuple      (tuple_q),
    .data       (tuple_data_o)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (in_valid_i)            next_state = ST_SRC_IP;
      ST_SRC_IP:    if (tuple_ready_i)         next_state = ST_DST_IP;
      ST_DST_IP:    if (tuple_ready_i)         next_state = ST_PORTS;
      ST_PORTS:     if (tuple_ready_i)         next_state = ST_PROTO;
      ST_PROTO:     if (tuple_ready_i)         next_state = ST_WAIT_CONN;
      ST_WAIT_CONN: if (conn_fire || to_hit)   next_state = ST_OUT;
      ST_OUT:       if (res_ready_i)           next_state = ST_IDLE;
      default:                                 next_state = ST_IDLE;
    endcase
  end

  // Request capture, latency/timeout counters, result registers and sequence tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tuple_q    <= '0;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      res_data_o <= '0;
      res_lat_o  <= '0;
      res_err_o  <= 1'b0;
      seq        <= '0;
    end else begin
      if (in_ready_o && in_valid_i) begin
        tuple_q <= '{src_ip:   in_src_ip_i,
                     dst_ip:   in_dst_ip_i,
                     src_port: in_src_port_i,
                     dst_port: in_dst_port_i,
                     proto:    in_proto_i};
        lat_cnt <= '0;
      end else if (beat_active || (state == ST_WAIT_CONN)) begin
        lat_cnt <= lat_next;
      end

      if (state == ST_WAIT_CONN) to_cnt <= to_cnt + 32'd1;
      else                       to_cnt <= '0;

      // A handshake on the timeout cycle still returns the id.
      if (conn_fire) begin
        res_data_o <= conn_data_i;
        res_err_o  <= 1'b0;
        res_lat_o  <= lat_next;
      end else if (to_hit) begin
        res_data_o <= '0;
        res_err_o  <= 1'b1;
        res_lat_o  <= lat_next;
      end

      if (res_valid_o && res_ready_i) seq <= seq + SEQ_W'(1);
    end
  end

endmodule
